// File: rtl/cp_remove.sv
// cp_remove: strips the cyclic prefix from an OFDM sample stream and forwards FFT_LEN useful samples per symbol
module cp_remove #(
  parameter int DW      = 18,
  parameter int FFT_LEN = 64,
  parameter int CP_LEN  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_real,
  input  logic [DW-1:0] din_imag,
  input  logic          din_valid,
  input  logic          sym_start,
  output logic [DW-1:0] dout_real,
  output logic [DW-1:0] dout_imag,
  output logic          dout_valid,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic [7:0]    sym_idx,
  output logic          align_err
);
  localparam int CW = $clog2(FFT_LEN + 1);
  localparam logic [CW-1:0] CP_LAST  = CW'(CP_LEN - 1);
  localparam logic [CW-1:0] FFT_LAST = CW'(FFT_LEN - 1);
  typedef enum logic [1:0] {IDLE, CP, DATA} state_t;
  localparam state_t ST_START = (CP_LEN == 1) ? DATA : CP;
  localparam logic [CW-1:0] CNT_START = (CP_LEN == 1) ? '0 : CW'(1);
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic fwd, sop, eop, err;
  // A sym_start sample is always CP sample 0; it only counts as misaligned off the natural boundary.
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    fwd   = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    err   = 1'b0;
    if (din_valid) begin
      if (sym_start) begin
        st_n  = ST_START;
        cnt_n = CNT_START;
        err   = (st == DATA) || (st == CP && cnt != '0);
      end else if (st == CP) begin
        st_n  = (cnt == CP_LAST) ? DATA : CP;
        cnt_n = (cnt == CP_LAST) ? '0 : cnt + 1'b1;
      end else if (st == DATA) begin
        fwd   = 1'b1;
        sop   = (cnt == '0);
        eop   = (cnt == FFT_LAST);
        st_n  = eop ? CP : DATA;
        cnt_n = eop ? '0 : cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      cnt        <= '0;
      dout_real  <= '0;
      dout_imag  <= '0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      align_err  <= 1'b0;
      sym_idx    <= '0;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      dout_valid <= fwd;
      dout_sop   <= sop;
      dout_eop   <= eop;
      align_err  <= err;
      if (fwd) begin
        dout_real <= din_real;
        dout_imag <= din_imag;
      end
      if (eop) sym_idx <= sym_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_cp_remove.sv
// tb_cp_remove: drives two cp_remove instances (CP_LEN 16 and 1) against a symbol-position reference model
module tb_cp_remove;
  localparam int DW = 18;
  localparam int FFT = 64;
  logic clk = 1'b0;
  logic rst, din_valid, sym_start;
  logic [DW-1:0] din_real, din_imag;
  logic [DW-1:0] o_re[2], o_im[2];
  logic o_val[2], o_sop[2], o_eop[2], o_err[2];
  logic [7:0] o_idx[2];
  int n_chk = 0, n_pass = 0;
  int pos[2] = '{-1, -1};
  int sym[2] = '{0, 0};
  int cpl[2] = '{16, 1};
  int n_out[2] = '{0, 0};
  always #5 clk = ~clk;
  cp_remove #(.DW(DW), .FFT_LEN(FFT), .CP_LEN(16)) dut0 (
    .clk(clk), .rst(rst), .din_real(din_real), .din_imag(din_imag),
    .din_valid(din_valid), .sym_start(sym_start),
    .dout_real(o_re[0]), .dout_imag(o_im[0]), .dout_valid(o_val[0]),
    .dout_sop(o_sop[0]), .dout_eop(o_eop[0]), .sym_idx(o_idx[0]), .align_err(o_err[0]));
  cp_remove #(.DW(DW), .FFT_LEN(FFT), .CP_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .din_real(din_real), .din_imag(din_imag),
    .din_valid(din_valid), .sym_start(sym_start),
    .dout_real(o_re[1]), .dout_imag(o_im[1]), .dout_valid(o_val[1]),
    .dout_sop(o_sop[1]), .dout_eop(o_eop[1]), .sym_idx(o_idx[1]), .align_err(o_err[1]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  // pos = position (0..CP+FFT-1) the next valid sample occupies in its symbol, -1 while unsynchronised
  task automatic step(input logic r, input logic v, input logic s, input logic [DW-1:0] re, input logic [DW-1:0] im);
    logic e_val[2], e_sop[2], e_eop[2], e_err[2];
    logic [DW-1:0] e_re[2], e_im[2];
    @(negedge clk);
    rst = r; din_valid = v; sym_start = s; din_real = re; din_imag = im;
    for (int i = 0; i < 2; i++) begin
      int cur;
      e_val[i] = 0; e_sop[i] = 0; e_eop[i] = 0; e_err[i] = 0; e_re[i] = 0; e_im[i] = 0;
      if (r) begin
        pos[i] = -1;
        sym[i] = 0;
      end else if (v) begin
        if (s) begin
          e_err[i] = (pos[i] != -1) && (pos[i] != 0);
          cur = 0;
        end else cur = pos[i];
        if (cur >= 0) begin
          if (cur >= cpl[i]) begin
            e_val[i] = 1; e_re[i] = re; e_im[i] = im;
            e_sop[i] = (cur == cpl[i]);
            e_eop[i] = (cur == cpl[i] + FFT - 1);
            if (e_eop[i]) sym[i] = (sym[i] + 1) % 256;
          end
          pos[i] = (cur + 1) % (cpl[i] + FFT);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("valid%0d", i), 32'(o_val[i]), 32'(e_val[i]));
      check($sformatf("err%0d", i), 32'(o_err[i]), 32'(e_err[i]));
      check($sformatf("sym_idx%0d", i), 32'(o_idx[i]), 32'(sym[i]));
      if (e_val[i] || r) begin
        check($sformatf("real%0d", i), 32'(o_re[i]), 32'(e_re[i]));
        check($sformatf("imag%0d", i), 32'(o_im[i]), 32'(e_im[i]));
        check($sformatf("sop%0d", i), 32'(o_sop[i]), 32'(e_sop[i]));
        check($sformatf("eop%0d", i), 32'(o_eop[i]), 32'(e_eop[i]));
      end
      if (o_val[i]) n_out[i]++;
    end
  endtask
  task automatic run(input int n, input int start_at, input int realign_at);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'b1, k == start_at || k == realign_at, DW'(k), ~DW'(k));
  endtask
  initial begin
    rst = 1'b1; din_valid = 1'b0; sym_start = 1'b0; din_real = '0; din_imag = '0;
    repeat (2) step(1'b1, 1'b1, 1'b1, DW'(5), DW'(7));
    n_out = '{0, 0};
    run(240, 0, -1);
    check("burst_outputs", 32'(n_out[0]), 32'd192);
    check("burst_sym_idx", 32'(o_idx[0]), 32'd3);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    begin
      int idx = 0;
      n_out = '{0, 0};
      for (int k = 0; idx < 240; k++) begin
        logic v = (k % 3) != 2;
        step(1'b0, v, v && idx == 0, DW'(idx), ~DW'(idx));
        if (v) idx++;
      end
      check("gapped_outputs", 32'(n_out[0]), 32'd192);
    end
    step(1'b1, 1'b0, 1'b0, '0, '0);
    run(150, 0, 116);
    check("realign_sym_idx", 32'(o_idx[0]), 32'd1);
    run(120, -1, -1);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    run(126, 0, -1);
    step(1'b1, 1'b1, 1'b0, DW'(126), DW'(126));
    n_out = '{0, 0};
    run(100, -1, -1);
    check("post_reset_discard", 32'(n_out[0]), 32'd0);
    run(200, 0, -1);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    n_out = '{0, 0};
    run(195, 0, -1);
    check("cp1_outputs", 32'(n_out[1]), 32'd192);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    run(24000, 0, -1);
    check("wrap_sym_idx", 32'(o_idx[0]), 32'd44);
    for (int k = 0; k < 4000; k++)
      step($urandom_range(499) == 0, $urandom_range(3) != 0, $urandom_range(99) == 0,
           DW'($urandom), DW'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
